alu_seq_psr: RTL and testbench

//  Parametrised, registered successor to the combinational 16-bit ALU. Executes the CR16-style
//  {opcode,opext} set on WIDTH-bit operands, and keeps CLFZN in an internal PSR so ADDC uses the

---
 rtl/alu_seq_psr_pkg.sv | 79 +++++++
 rtl/alu_seq_psr_if.sv | 26 ++
 rtl/alu_seq_psr_shift_iter.sv | 50 +++++
 rtl/alu_seq_psr.sv | 149 ++++++++++++++
 tb/tb_alu_seq_psr.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_psr_pkg.sv
// rtl/alu_seq_psr_pkg.sv - opcode map, PSR bit positions, FSM states and decode helper
package alu_seq_pkg;

    localparam logic [3:0] OPC_RR    = 4'b0000;
    localparam logic [3:0] OPC_ADDI  = 4'b0101;
    localparam logic [3:0] OPC_ADDUI = 4'b0110;
    localparam logic [3:0] OPC_ADDCI = 4'b0111;
    localparam logic [3:0] OPC_LSH   = 4'b1000;
    localparam logic [3:0] OPC_SUBI  = 4'b1001;
    localparam logic [3:0] OPC_EXT   = 4'b1010;
    localparam logic [3:0] OPC_CMPI  = 4'b1011;
    localparam logic [3:0] OPC_MOVI  = 4'b1101;
    localparam logic [3:0] OPC_RSHI  = 4'b1110;

    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_RSH  = 4'b1110;
    localparam logic [3:0] EXT_NOT  = 4'b0011;
    localparam logic [3:0] EXT_ARSH = 4'b0100;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic {IDLE, SHIFT} state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_CMP, OP_AND,
        OP_OR, OP_XOR, OP_NOT, OP_MOV, OP_LSH, OP_RSH, OP_ARSH
    } alu_op_e;

    function automatic alu_op_e alu_decode(input logic [3:0] opcode, input logic [3:0] opext);
        alu_op_e op;
        op = OP_NOP;
        case (opcode)
            OPC_RR: begin
                case (opext)
                    EXT_ADD:  op = OP_ADD;
                    EXT_ADDU: op = OP_ADDU;
                    EXT_ADDC: op = OP_ADDC;
                    EXT_SUB:  op = OP_SUB;
                    EXT_CMP:  op = OP_CMP;
                    EXT_AND:  op = OP_AND;
                    EXT_OR:   op = OP_OR;
                    EXT_XOR:  op = OP_XOR;
                    EXT_MOV:  op = OP_MOV;
                    EXT_RSH:  op = OP_RSH;
                    default:  op = OP_NOP;
                endcase
            end
            OPC_ADDI:  op = OP_ADD;
            OPC_ADDUI: op = OP_ADDU;
            OPC_ADDCI: op = OP_ADDC;
            OPC_SUBI:  op = OP_SUB;
            OPC_CMPI:  op = OP_CMP;
            OPC_MOVI:  op = OP_MOV;
            OPC_RSHI:  op = OP_RSH;
            OPC_LSH:   op = OP_LSH;
            OPC_EXT: begin
                if (opext == EXT_NOT)
                    op = OP_NOT;
                else if (opext == EXT_ARSH)
                    op = OP_ARSH;
            end
            default:   op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_seq_psr_if.sv
// rtl/alu_seq_psr_if.sv - request/result handshake bundle between decode, ALU and writeback
interface alu_seq_psr_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [3:0]       opext;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             res_we;
    logic [4:0]       psr;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, opcode, opext, a, b, out_ready,
        input  in_ready, res, res_we, psr, out_valid
    );

    modport slave (
        input  in_valid, opcode, opext, a, b, out_ready,
        output in_ready, res, res_we, psr, out_valid
    );
endinterface

// File: rtl/alu_seq_psr_shift_iter.sv
// rtl/alu_seq_psr_shift_iter.sv - iterative one-bit-per-cycle shifter
module alu_shift_iter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               right_i,
    input  logic               arith_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0]   value_i,
    output logic [WIDTH-1:0]   first_o,
    output logic [WIDTH-1:0]   step_o,
    output logic               last_o
);
    logic [WIDTH-1:0]   value_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               right_q;
    logic               arith_q;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                               input logic right, input logic arith);
        if (right)
            return {arith & v[WIDTH-1], v[WIDTH-1:1]};
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    // first_o lets the caller take the first bit on the accept edge itself
    assign first_o = shift1(value_i, right_i, arith_i);
    assign step_o  = shift1(value_q, right_q, arith_q);
    assign last_o  = (cnt_q == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (load_i) begin
            value_q <= first_o;
            cnt_q   <= amt_i;
            right_q <= right_i;
            arith_q <= arith_i;
        end else if (cnt_q != '0) begin
            value_q <= step_o;
            cnt_q   <= cnt_q - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/alu_seq_psr.sv
// rtl/alu_seq_psr.sv - registered ALU with PSR, iterative shifter and output holding register
module alu_seq_psr
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          reset_n,
    alu_seq_psr_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHAMT_W-1:0] AMT_MAX = SHAMT_W'(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               res_we_q, res_we_d;
    logic [4:0]         psr_q, psr_d;
    logic               out_valid_q, out_valid_d;

    alu_op_e            op;
    logic               in_ready, accept, is_shift, shift_load, shift_last, carry_in;
    logic [SHAMT_W-1:0] amt_raw, amt;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res, first_val, step_val;
    logic               alu_we;
    logic [4:0]         alu_psr;

    assign op       = alu_decode(bus.opcode, bus.opext);
    assign in_ready = reset_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign is_shift = (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
    assign amt_raw  = bus.b[SHAMT_W-1:0];
    assign amt      = (amt_raw > AMT_MAX) ? AMT_MAX : amt_raw;
    assign carry_in = (op == OP_ADDC) ? psr_q[PSR_C] : 1'b0;
    assign sum      = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, carry_in};
    assign diff     = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b1;
        alu_psr = psr_q;
        case (op)
            OP_ADD, OP_ADDC: begin
                alu_res        = sum[MSB:0];
                alu_psr[PSR_C] = sum[WIDTH];
                alu_psr[PSR_F] = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_ADDU: begin
                alu_res        = sum[MSB:0];
                alu_psr[PSR_C] = sum[WIDTH];
                alu_psr[PSR_F] = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res        = diff[MSB:0];
                alu_psr[PSR_C] = diff[WIDTH];
                alu_psr[PSR_F] = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_CMP: begin
                alu_we         = 1'b0;
                alu_psr[PSR_Z] = (bus.a == bus.b);
                alu_psr[PSR_L] = diff[WIDTH];
                alu_psr[PSR_N] = $signed(bus.a) < $signed(bus.b);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOT: alu_res = ~bus.a;
            OP_MOV: alu_res = bus.b;
            OP_LSH, OP_RSH, OP_ARSH:
                alu_res = (amt == '0) ? bus.a : first_val;
            default: alu_we = 1'b0;
        endcase
    end

    alu_shift_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (shift_load),
        .right_i (op != OP_LSH),
        .arith_i (op == OP_ARSH),
        .amt_i   (amt - SHAMT_W'(1)),
        .value_i (bus.a),
        .first_o (first_val),
        .step_o  (step_val),
        .last_o  (shift_last)
    );

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_we_d    = res_we_q;
        psr_d       = psr_q;
        out_valid_d = out_valid_q;
        shift_load  = 1'b0;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            res_d       = '0;
            res_we_d    = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    psr_d = alu_psr;
                    // amounts of 0 and 1 finish on the accept edge
                    if (is_shift && (amt > SHAMT_W'(1))) begin
                        shift_load = 1'b1;
                        state_d    = SHIFT;
                    end else begin
                        res_d       = alu_res;
                        res_we_d    = alu_we;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    res_d       = step_val;
                    res_we_d    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            res_we_q    <= 1'b0;
            psr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_we_q    <= res_we_d;
            psr_q       <= psr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res       = res_q;
    assign bus.res_we    = res_we_q;
    assign bus.psr       = psr_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq_psr.sv
// tb/tb_alu_seq_psr.sv - directed vector bench for alu_seq_psr
module tb_alu_seq_psr;
    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  ext;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        we;
        logic [4:0]  psr;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[30];

    alu_seq_psr_if #(.WIDTH(16)) bus();

    alu_seq_psr #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] opc, input logic [3:0] ext,
                         input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.opext    = ext;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int n;
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v.opc, v.ext, v.a, v.b);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_res_we"}, 32'(bus.res_we), 32'(v.we));
        if (v.we)
            chk({tag, "_res"}, 32'(bus.res), 32'(v.res));
        chk({tag, "_psr"}, 32'(bus.psr), 32'(v.psr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        //             opc      ext      a        b        res      we    psr        lat
        vecs[0]  = '{4'b0000, 4'b0101, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 5'b00100, 1};
        vecs[1]  = '{4'b0000, 4'b0110, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5'b10100, 1};
        vecs[2]  = '{4'b0000, 4'b0111, 16'h0000, 16'h0000, 16'h0001, 1'b1, 5'b00000, 1};
        vecs[3]  = '{4'b0000, 4'b1011, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 5'b01000, 1};
        vecs[4]  = '{4'b1011, 4'b0000, 16'h1234, 16'h1234, 16'h0000, 1'b0, 5'b00010, 1};
        vecs[5]  = '{4'b0000, 4'b1001, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 5'b10010, 1};
        vecs[6]  = '{4'b0111, 4'b0000, 16'h0001, 16'h0001, 16'h0003, 1'b1, 5'b00010, 1};
        vecs[7]  = '{4'b0000, 4'b0001, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1, 5'b00010, 1};
        vecs[8]  = '{4'b0000, 4'b0010, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b1, 5'b00010, 1};
        vecs[9]  = '{4'b0000, 4'b0011, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b1, 5'b00010, 1};
        vecs[10] = '{4'b1010, 4'b0011, 16'h00FF, 16'h1234, 16'hFF00, 1'b1, 5'b00010, 1};
        vecs[11] = '{4'b0000, 4'b1101, 16'h1111, 16'hABCD, 16'hABCD, 1'b1, 5'b00010, 1};
        vecs[12] = '{4'b1101, 4'b0110, 16'h2222, 16'h1357, 16'h1357, 1'b1, 5'b00010, 1};
        vecs[13] = '{4'b1001, 4'b0000, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 5'b00110, 1};
        vecs[14] = '{4'b0000, 4'b1011, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 5'b00101, 1};
        vecs[15] = '{4'b0000, 4'b0000, 16'h1234, 16'h5678, 16'h0000, 1'b0, 5'b00101, 1};
        vecs[16] = '{4'b0101, 4'b0000, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 5'b10001, 1};
        vecs[17] = '{4'b0110, 4'b0000, 16'h0001, 16'h0002, 16'h0003, 1'b1, 5'b00001, 1};
        vecs[18] = '{4'b1000, 4'b0100, 16'h0001, 16'h0004, 16'h0010, 1'b1, 5'b00001, 4};
        vecs[19] = '{4'b1000, 4'b0000, 16'h00FF, 16'h0000, 16'h00FF, 1'b1, 5'b00001, 1};
        vecs[20] = '{4'b0000, 4'b1110, 16'h8000, 16'h0001, 16'h4000, 1'b1, 5'b00001, 1};
        vecs[21] = '{4'b1110, 4'b0000, 16'hF000, 16'h0004, 16'h0F00, 1'b1, 5'b00001, 4};
        vecs[22] = '{4'b1010, 4'b0100, 16'h8000, 16'h0003, 16'hF000, 1'b1, 5'b00001, 3};
        vecs[23] = '{4'b1000, 4'b0100, 16'hFFFF, 16'h0014, 16'h0000, 1'b1, 5'b00001, 16};
        vecs[24] = '{4'b1010, 4'b0100, 16'h8000, 16'h001F, 16'hFFFF, 1'b1, 5'b00001, 16};
        vecs[25] = '{4'b0000, 4'b1110, 16'hFFFF, 16'h0010, 16'h0000, 1'b1, 5'b00001, 16};
        vecs[26] = '{4'b1000, 4'b0001, 16'h0003, 16'h0021, 16'h0006, 1'b1, 5'b00001, 1};
        vecs[27] = '{4'b1010, 4'b0000, 16'h5555, 16'h0001, 16'h0000, 1'b0, 5'b00001, 1};
        vecs[28] = '{4'b1010, 4'b0100, 16'h7FF0, 16'h0002, 16'h1FFC, 1'b1, 5'b00001, 2};
        vecs[29] = '{4'b1111, 4'b1111, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 5'b00001, 1};

        bus.in_valid  = 1'b0;
        bus.opcode    = 4'h0;
        bus.opext     = 4'h0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_res_we", 32'(bus.res_we), 32'd0);
        chk("rst_psr", 32'(bus.psr), 32'd0);
        chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_high", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i])
            run_op(vecs[i], i);

        // stall: result held, next op refused until out_ready returns
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(4'b0000, 4'b0101, 16'h0001, 16'h0002);
        @(negedge clk);
        drive(4'b1101, 4'b0000, 16'h0000, 16'h5555);
        chk("stall_first_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_first_res", 32'(bus.res), 32'h0003);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_res", k), 32'(bus.res), 32'h0003);
            chk($sformatf("stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall_next_res", 32'(bus.res), 32'h5555);
        chk("stall_next_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_psr", 32'(bus.psr), 32'(5'b00001));
        @(negedge clk);
        chk("taken_valid", 32'(bus.out_valid), 32'd0);
        chk("taken_res", 32'(bus.res), 32'd0);

        // back-to-back ADDU -> ADDC uses the carry just produced
        drive(4'b0000, 4'b0110, 16'hFFFF, 16'h0001);
        @(negedge clk);
        chk("b2b_addu_res", 32'(bus.res), 32'h0000);
        chk("b2b_addu_psr", 32'(bus.psr), 32'(5'b10101));
        drive(4'b0000, 4'b0111, 16'h0000, 16'h0000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b_addc_res", 32'(bus.res), 32'h0001);
        chk("b2b_addc_psr", 32'(bus.psr), 32'(5'b00001));

        // reset in the middle of a long shift
        @(negedge clk);
        drive(4'b1000, 4'b0100, 16'h0001, 16'h000A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_shift_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_psr", 32'(bus.psr), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        ones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid)
                ones++;
        end
        chk("post_rst_no_result", 32'(ones), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
